// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, mode encodings and elaboration-time constant helpers.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ROTATION  = 1'b0;
  localparam logic MODE_VECTORING = 1'b1;

  localparam real PI = 3.14159265358979323846;

  // Angles use binary units where 1.0 is a full turn, so 90 degrees is a quarter of the scale.
  function automatic int unsigned angle_90(input int unsigned frac_bits);
    return 32'd1 << (frac_bits - 32'd2);
  endfunction

  function automatic int unsigned inv_k(input int unsigned frac_bits);
    real scale;
    scale = real'(64'(1) << frac_bits);
    return unsigned'($rtoi(0.607253 * scale + 0.5));
  endfunction

  function automatic int unsigned atan_entry(input int unsigned frac_bits, input int unsigned idx);
    real scale;
    real ratio;
    scale = real'(64'(1) << frac_bits);
    ratio = 1.0 / real'(64'(1) << idx);
    return unsigned'($rtoi($atan(ratio) / (2.0 * PI) * scale + 0.5));
  endfunction

endpackage

// File: rtl/cordic_iterative_engine_if.sv
// Operand/result handshake bundle between a CORDIC producer/consumer and the engine.
interface cordic_iterative_engine_if #(
  parameter int unsigned W = 25
) ();

  logic                in_valid;
  logic                in_ready;
  logic                mode_in;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] z_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] z_out;

  modport master (
    output in_valid, mode_in, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  modport slave (
    input  in_valid, mode_in, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: atan(2^-i) in binary angle units, one entry per micro-rotation.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC_BITS  = 22,
  parameter int unsigned ITERATIONS = 22
) (
  input  logic [$clog2(ITERATIONS)-1:0] idx,
  output logic signed [FRAC_BITS+2:0]   atan_c
);

  localparam int unsigned W = FRAC_BITS + 3;

  logic signed [W-1:0] lut_c [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_lut
    assign lut_c[g] = W'(atan_entry(FRAC_BITS, g));
  end

  assign atan_c = lut_c[idx];

endmodule

// File: rtl/cordic_iterative_engine.sv
// Iterative circular CORDIC (rotation/vectoring) with quadrant pre-rotation, one shared
// shift-add stage and optional 1/K gain compensation behind a valid/ready handshake.
module cordic_iterative_engine
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC_BITS  = 22,
  parameter int unsigned ITERATIONS = 22,
  parameter bit          GAIN_COMP  = 1'b0
) (
  input logic                      clock_pulse,
  input logic                      reset,
  cordic_iterative_engine_if.slave bus
);

  localparam int unsigned W     = FRAC_BITS + 3;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = $clog2(ITERATIONS);

  localparam logic signed [W-1:0] QUARTER  = W'(angle_90(FRAC_BITS));
  localparam logic signed [W-1:0] INV_K    = W'(inv_k(FRAC_BITS));
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(ITERATIONS - 1);

  state_e              state;
  state_e              state_n;
  logic signed [W-1:0] x_q, y_q, z_q;
  logic signed [W-1:0] x_n, y_n, z_n;
  logic signed [W-1:0] x_pre, y_pre, z_pre;
  logic signed [W-1:0] x_sh, y_sh;
  logic signed [W-1:0] atan_c;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                mode_q, mode_n;
  logic                accept_c, handoff_c, last_c, dir_pos_c;

  assign accept_c  = (state == ST_IDLE) && bus.in_valid;
  assign handoff_c = (state == ST_DONE) && bus.out_ready;
  assign last_c    = (cnt_q == LAST_CNT);

  cordic_atan_rom #(
    .FRAC_BITS (FRAC_BITS),
    .ITERATIONS(ITERATIONS)
  ) u_atan_rom (
    .idx   (cnt_q),
    .atan_c(atan_c)
  );

  // State register.
  always_ff @(posedge clock_pulse) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept_c) state_n = ST_ITER;
      ST_ITER:  if (last_c) state_n = GAIN_COMP ? ST_SCALE : ST_DONE;
      ST_SCALE: state_n = ST_DONE;
      ST_DONE:  if (handoff_c) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Quadrant pre-rotation keeps the residual angle inside the CORDIC convergence range.
  always_comb begin
    x_pre = bus.x_in;
    y_pre = bus.y_in;
    z_pre = bus.z_in;
    if (bus.mode_in == MODE_ROTATION) begin
      if (bus.z_in > QUARTER) begin
        x_pre = -bus.y_in;
        y_pre = bus.x_in;
        z_pre = bus.z_in - QUARTER;
      end else if (bus.z_in < -QUARTER) begin
        x_pre = bus.y_in;
        y_pre = -bus.x_in;
        z_pre = bus.z_in + QUARTER;
      end
    end else if (bus.x_in[W-1]) begin
      if (!bus.y_in[W-1]) begin
        x_pre = bus.y_in;
        y_pre = -bus.x_in;
        z_pre = bus.z_in + QUARTER;
      end else begin
        x_pre = -bus.y_in;
        y_pre = bus.x_in;
        z_pre = bus.z_in - QUARTER;
      end
    end
  end

  assign dir_pos_c = (mode_q == MODE_ROTATION) ? !z_q[W-1] : y_q[W-1];
  assign x_sh      = x_q >>> cnt_q;
  assign y_sh      = y_q >>> cnt_q;

  // Datapath next values: load, micro-rotation step, or gain scaling.
  always_comb begin
    x_n    = x_q;
    y_n    = y_q;
    z_n    = z_q;
    cnt_n  = cnt_q;
    mode_n = mode_q;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          x_n    = x_pre;
          y_n    = y_pre;
          z_n    = z_pre;
          cnt_n  = '0;
          mode_n = bus.mode_in;
        end
      end
      ST_ITER: begin
        if (dir_pos_c) begin
          x_n = x_q - y_sh;
          y_n = y_q + x_sh;
          z_n = z_q - atan_c;
        end else begin
          x_n = x_q + y_sh;
          y_n = y_q - x_sh;
          z_n = z_q + atan_c;
        end
        cnt_n = last_c ? '0 : cnt_q + CNT_W'(1);
      end
      ST_SCALE: begin
        x_n = W'((PW'(x_q) * PW'(INV_K)) >>> FRAC_BITS);
        y_n = W'((PW'(y_q) * PW'(INV_K)) >>> FRAC_BITS);
      end
      default: ;
    endcase
  end

  // Working registers and registered handshake/result outputs.
  always_ff @(posedge clock_pulse) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      z_q           <= '0;
      cnt_q         <= '0;
      mode_q        <= MODE_ROTATION;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.z_out     <= '0;
    end else begin
      x_q           <= x_n;
      y_q           <= y_n;
      z_q           <= z_n;
      cnt_q         <= cnt_n;
      mode_q        <= mode_n;
      bus.in_ready  <= (state_n == ST_IDLE);
      bus.out_valid <= (state_n == ST_DONE);
      if ((state != ST_DONE) && (state_n == ST_DONE)) begin
        bus.x_out <= x_n;
        bus.y_out <= y_n;
        bus.z_out <= z_n;
      end
    end
  end

endmodule

// File: tb/tb_cordic_iterative_engine.sv
// Directed self-checking bench for cordic_iterative_engine (raw and gain-compensated builds).
module tb_cordic_iterative_engine;
  import cordic_pkg::*;

  localparam int unsigned FRAC_BITS  = 22;
  localparam int unsigned ITERATIONS = 22;
  localparam int unsigned W          = FRAC_BITS + 3;
  localparam int          TOL        = 64;
  localparam int          TIMEOUT    = 100;

  logic clock_pulse = 1'b0;
  logic reset       = 1'b1;
  int   checks      = 0;
  int   errors      = 0;

  cordic_iterative_engine_if #(.W(W)) bus ();
  cordic_iterative_engine_if #(.W(W)) bus_gc ();

  cordic_iterative_engine #(
    .FRAC_BITS(FRAC_BITS), .ITERATIONS(ITERATIONS), .GAIN_COMP(1'b0)
  ) dut (
    .clock_pulse(clock_pulse), .reset(reset), .bus(bus)
  );

  cordic_iterative_engine #(
    .FRAC_BITS(FRAC_BITS), .ITERATIONS(ITERATIONS), .GAIN_COMP(1'b1)
  ) dut_gc (
    .clock_pulse(clock_pulse), .reset(reset), .bus(bus_gc)
  );

  always #5 clock_pulse = ~clock_pulse;

  task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    checks++;
    assert ((diff <= TOL) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, TOL);
    end
  endtask

  // Issue one operation on the raw engine, wait for its result, then hand it off.
  task automatic do_op(input logic m, input int xi, input int yi, input int zi,
                       output int lat, output int xo, output int yo, output int zo);
    bus.mode_in  = m;
    bus.x_in     = W'(xi);
    bus.y_in     = W'(yi);
    bus.z_in     = W'(zi);
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clock_pulse); #1;
      lat++;
      if (lat == 1) bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < TIMEOUT);
    xo = 32'(bus.x_out);
    yo = 32'(bus.y_out);
    zo = 32'(bus.z_out);
    bus.out_ready = 1'b1;
    @(posedge clock_pulse); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat, xo, yo, zo, seen, n_in, n_out;
    logic op_m [4];
    int   op_x [4], op_y [4], op_z [4], ex_x [4], ex_y [4];
    int   res_x [4], res_y [4], res_t [4];

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode_in = MODE_ROTATION;
    bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
    bus_gc.in_valid = 1'b0; bus_gc.out_ready = 1'b0; bus_gc.mode_in = MODE_ROTATION;
    bus_gc.x_in = '0; bus_gc.y_in = '0; bus_gc.z_in = '0;

    // Reset state.
    reset = 1'b1;
    repeat (2) @(posedge clock_pulse);
    #1;
    check_eq("reset_in_ready", 32'(bus.in_ready), 1);
    check_eq("reset_out_valid", 32'(bus.out_valid), 0);
    check_eq("reset_x_out", 32'(bus.x_out), 0);
    check_eq("reset_y_out", 32'(bus.y_out), 0);
    check_eq("reset_z_out", 32'(bus.z_out), 0);
    reset = 1'b0;
    @(posedge clock_pulse); #1;

    // Rotation by 30 degrees of (1/K, 0).
    do_op(MODE_ROTATION, 2546995, 0, 349525, lat, xo, yo, zo);
    check_eq("rot30_latency", lat, 23);
    check_near("rot30_x", xo, 3632415);
    check_near("rot30_y", yo, 2097152);
    check_near("rot30_z", zo, 0);
    check_eq("rot30_in_ready_after", 32'(bus.in_ready), 1);
    check_eq("rot30_out_valid_after", 32'(bus.out_valid), 0);

    // Rotation by +150 and -150 degrees exercises both pre-rotation branches.
    do_op(MODE_ROTATION, 2546995, 0, 1747627, lat, xo, yo, zo);
    check_near("rot150_x", xo, -3632415);
    check_near("rot150_y", yo, 2097152);
    do_op(MODE_ROTATION, 2546995, 0, -1747627, lat, xo, yo, zo);
    check_near("rotm150_x", xo, -3632415);
    check_near("rotm150_y", yo, -2097152);

    // Vectoring of (1,1) and of (-1,1) through pre-rotation.
    do_op(MODE_VECTORING, 4194304, 4194304, 0, lat, xo, yo, zo);
    check_eq("vec45_latency", lat, 23);
    check_near("vec45_x", xo, 9767992);
    check_near("vec45_y", yo, 0);
    check_near("vec45_z", zo, 524288);
    do_op(MODE_VECTORING, -4194304, 4194304, 0, lat, xo, yo, zo);
    check_near("vec135_x", xo, 9767992);
    check_near("vec135_y", yo, 0);
    check_near("vec135_z", zo, 1572864);

    // Gain-compensated build: one extra cycle, magnitude sqrt(2).
    bus_gc.mode_in = MODE_VECTORING;
    bus_gc.x_in = W'(4194304); bus_gc.y_in = W'(4194304); bus_gc.z_in = '0;
    bus_gc.in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clock_pulse); #1;
      lat++;
      if (lat == 1) bus_gc.in_valid = 1'b0;
    end while (!bus_gc.out_valid && lat < TIMEOUT);
    check_eq("gc_latency", lat, 24);
    check_near("gc_x", 32'(bus_gc.x_out), 5931642);
    check_near("gc_y", 32'(bus_gc.y_out), 0);
    check_near("gc_z", 32'(bus_gc.z_out), 524288);
    bus_gc.out_ready = 1'b1;
    @(posedge clock_pulse); #1;
    bus_gc.out_ready = 1'b0;
    check_eq("gc_in_ready_after", 32'(bus_gc.in_ready), 1);

    // Backpressure: result held for 10 cycles while a new request is pending.
    bus.mode_in = MODE_ROTATION;
    bus.x_in = W'(2546995); bus.y_in = '0; bus.z_in = W'(349525);
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clock_pulse); #1;
      lat++;
      if (lat == 1) begin
        bus.mode_in = MODE_VECTORING;
        bus.x_in = W'(4194304); bus.y_in = W'(4194304); bus.z_in = '0;
      end
    end while (!bus.out_valid && lat < TIMEOUT);
    check_eq("bp_latency", lat, 23);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock_pulse); #1;
      check_eq("bp_out_valid_held", 32'(bus.out_valid), 1);
      check_eq("bp_in_ready_low", 32'(bus.in_ready), 0);
      check_near("bp_x_stable", 32'(bus.x_out), 3632415);
      check_near("bp_y_stable", 32'(bus.y_out), 2097152);
    end
    bus.out_ready = 1'b1;
    @(posedge clock_pulse); #1;
    bus.out_ready = 1'b0;
    check_eq("bp_in_ready_after", 32'(bus.in_ready), 1);
    check_eq("bp_out_valid_after", 32'(bus.out_valid), 0);
    // The pending request is accepted now, exactly once.
    lat = 0;
    do begin
      @(posedge clock_pulse); #1;
      lat++;
      if (lat == 1) bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < TIMEOUT);
    check_eq("bp_next_latency", lat, 23);
    check_near("bp_next_x", 32'(bus.x_out), 9767992);
    check_near("bp_next_z", 32'(bus.z_out), 524288);
    bus.out_ready = 1'b1;
    @(posedge clock_pulse); #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of iterating aborts the operation.
    bus.mode_in = MODE_ROTATION;
    bus.x_in = W'(2546995); bus.y_in = '0; bus.z_in = W'(349525);
    bus.in_valid = 1'b1;
    @(posedge clock_pulse); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clock_pulse);
    #1;
    reset = 1'b1;
    @(posedge clock_pulse); #1;
    check_eq("abort_in_ready", 32'(bus.in_ready), 1);
    check_eq("abort_out_valid", 32'(bus.out_valid), 0);
    check_eq("abort_x_out", 32'(bus.x_out), 0);
    check_eq("abort_y_out", 32'(bus.y_out), 0);
    check_eq("abort_z_out", 32'(bus.z_out), 0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock_pulse); #1;
      if (bus.out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);
    do_op(MODE_ROTATION, 2546995, 0, 1747627, lat, xo, yo, zo);
    check_eq("post_abort_latency", lat, 23);
    check_near("post_abort_x", xo, -3632415);
    check_near("post_abort_y", yo, 2097152);

    // Back-to-back with in_valid and out_ready held high.
    op_m[0] = MODE_ROTATION;  op_x[0] = 2546995; op_y[0] = 0;       op_z[0] = 349525;
    op_m[1] = MODE_ROTATION;  op_x[1] = 2546995; op_y[1] = 0;       op_z[1] = 1747627;
    op_m[2] = MODE_ROTATION;  op_x[2] = 2546995; op_y[2] = 0;       op_z[2] = -1747627;
    op_m[3] = MODE_VECTORING; op_x[3] = 4194304; op_y[3] = 4194304; op_z[3] = 0;
    ex_x[0] = 3632415;  ex_y[0] = 2097152;
    ex_x[1] = -3632415; ex_y[1] = 2097152;
    ex_x[2] = -3632415; ex_y[2] = -2097152;
    ex_x[3] = 9767992;  ex_y[3] = 0;
    n_in = 0; n_out = 0;
    bus.mode_in = op_m[0]; bus.x_in = W'(op_x[0]); bus.y_in = W'(op_y[0]); bus.z_in = W'(op_z[0]);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      logic acc;
      acc = bus.in_ready && bus.in_valid;
      @(posedge clock_pulse); #1;
      if (acc) begin
        n_in++;
        if (n_in < 4) begin
          bus.mode_in = op_m[n_in];
          bus.x_in = W'(op_x[n_in]); bus.y_in = W'(op_y[n_in]); bus.z_in = W'(op_z[n_in]);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        res_x[n_out] = 32'(bus.x_out);
        res_y[n_out] = 32'(bus.y_out);
        res_t[n_out] = c;
        n_out++;
        if (n_out == 4) break;
      end
    end
    bus.in_valid = 1'b0;
    check_eq("b2b_result_count", n_out, 4);
    if (n_out == 4) begin
      for (int k = 0; k < 4; k++) begin
        check_near($sformatf("b2b_x%0d", k), res_x[k], ex_x[k]);
        check_near($sformatf("b2b_y%0d", k), res_y[k], ex_y[k]);
        if (k > 0) check_eq($sformatf("b2b_spacing%0d", k), res_t[k] - res_t[k-1], 24);
      end
    end
    @(posedge clock_pulse); #1;
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
